// File: rtl/arbiter_nx1.sv
// -----------------------------------------------------------------------------
// arbiter_nx1
//
// N-master to 1-slave bus arbiter. It grants one master at a time, either
// round-robin or fixed priority (lowest index wins), and forwards that
// master's request fields downstream. A master can keep the grant across
// consecutive transactions (for example an AMO read-modify-write) by holding
// i_lock at ack time. A lock with no follow-on request is dropped after
// LOCK_TIMEOUT idle cycles.
//
// Handshake: a master raises i_bus_en[k] and holds its request fields stable
// until o_ack[k] is high. Downstream sees o_bus_en while the arbiter is BUSY.
// i_ack completes the granted transfer combinationally (o_ack[grant] = i_ack)
// in the same cycle, and the grant is released on that clock edge.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_bus_en   [N]           per-master request
//   i_wr_en    [N]           per-master write(1)/read(0)
//   i_wr_data  [N*XLEN]      packed write data, port k at [k*XLEN +: XLEN]
//   i_addr     [N*XLEN]      packed address, same layout
//   i_byte_en  [N*4]         packed byte enables
//   i_atomic   [N]           per-master atomic flag
//   i_operation[N*7]         packed funct7 of the atomic op
//   i_lock     [N]           keep the grant after the current ack
//   o_ack      [N]           per-master ack, one-hot or zero
//   o_rd_data  [N*XLEN]      packed read data, only the granted slice non-zero
//   i_ack, i_rd_data         downstream completion and read data
//   o_id                     index of the granted master
//   o_bus_en .. o_operation  fields forwarded from the granted master
//   o_dbg_state              FSM state (0 IDLE, 1 BUSY, 2 LOCKED)
// -----------------------------------------------------------------------------
module arbiter_nx1 #(
  parameter int N_PORTS      = 4,   // must be >= 2
  parameter int XLEN         = 32,
  parameter int ROUND_ROBIN  = 1,   // 1 round-robin, 0 fixed priority
  parameter int LOCK_TIMEOUT = 16,  // must be >= 1
  localparam int ID_W        = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,

  input  logic [N_PORTS-1:0]      i_bus_en,
  input  logic [N_PORTS-1:0]      i_wr_en,
  input  logic [N_PORTS*XLEN-1:0] i_wr_data,
  input  logic [N_PORTS*XLEN-1:0] i_addr,
  input  logic [N_PORTS*4-1:0]    i_byte_en,
  input  logic [N_PORTS-1:0]      i_atomic,
  input  logic [N_PORTS*7-1:0]    i_operation,
  input  logic [N_PORTS-1:0]      i_lock,
  output logic [N_PORTS-1:0]      o_ack,
  output logic [N_PORTS*XLEN-1:0] o_rd_data,

  input  logic                    i_ack,
  input  logic [XLEN-1:0]         i_rd_data,
  output logic [ID_W-1:0]         o_id,
  output logic                    o_bus_en,
  output logic                    o_wr_en,
  output logic [XLEN-1:0]         o_wr_data,
  output logic [XLEN-1:0]         o_addr,
  output logic [3:0]              o_byte_en,
  output logic                    o_atomic,
  output logic [6:0]              o_operation,

  output logic [1:0]              o_dbg_state
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   grant, grant_d;
  logic [ID_W-1:0]   last, last_d;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_d;

  // Slice of the currently granted master.
  logic              sel_bus_en;
  logic              sel_wr_en;
  logic [XLEN-1:0]   sel_wr_data;
  logic [XLEN-1:0]   sel_addr;
  logic [3:0]        sel_byte_en;
  logic              sel_atomic;
  logic [6:0]        sel_operation;
  logic              sel_lock;

  logic [ID_W-1:0]   winner;
  logic              any_req;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------

  // First requester strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [ID_W-1:0] pick_rr(input logic [N_PORTS-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic found;
    int   idx;
    pick_rr = '0;
    found   = 1'b0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = (int'(ptr) + i) % N_PORTS;
      if (!found && req[idx]) begin
        found   = 1'b1;
        pick_rr = ID_W'(idx);
      end
    end
  endfunction

  // Lowest requesting index; scanning downward lets the lowest one win.
  function automatic logic [ID_W-1:0] pick_fixed(input logic [N_PORTS-1:0] req);
    pick_fixed = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_fixed = ID_W'(i);
      end
    end
  endfunction

  always_comb begin
    any_req = |i_bus_en;
    if (ROUND_ROBIN != 0) begin
      winner = pick_rr(i_bus_en, last);
    end else begin
      winner = pick_fixed(i_bus_en);
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-slice mux
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_bus_en    = 1'b0;
    sel_wr_en     = 1'b0;
    sel_wr_data   = '0;
    sel_addr      = '0;
    sel_byte_en   = '0;
    sel_atomic    = 1'b0;
    sel_operation = '0;
    sel_lock      = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant == ID_W'(k)) begin
        sel_bus_en    = i_bus_en[k];
        sel_wr_en     = i_wr_en[k];
        sel_wr_data   = i_wr_data[k*XLEN +: XLEN];
        sel_addr      = i_addr[k*XLEN +: XLEN];
        sel_byte_en   = i_byte_en[k*4 +: 4];
        sel_atomic    = i_atomic[k];
        sel_operation = i_operation[k*7 +: 7];
        sel_lock      = i_lock[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      grant    <= '0;
      last     <= ID_W'(N_PORTS - 1);  // port 0 gets first priority
      lock_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      last     <= last_d;
      lock_cnt <= lock_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state;
    grant_d    = grant;
    last_d     = last;
    lock_cnt_d = lock_cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_ack) begin
          last_d = grant;
          if (sel_lock) begin
            state_d    = ST_LOCKED;
            lock_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCKED: begin
        // Only the holder matters here; it re-enters BUSY without arbitration.
        if (sel_bus_en) begin
          state_d = ST_BUSY;
        end else if (!sel_lock || lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: downstream fields and acks only live in BUSY
  // ---------------------------------------------------------------------------
  always_comb begin
    o_bus_en    = 1'b0;
    o_wr_en     = 1'b0;
    o_wr_data   = '0;
    o_addr      = '0;
    o_byte_en   = '0;
    o_atomic    = 1'b0;
    o_operation = '0;
    o_id        = '0;
    o_ack       = '0;
    o_rd_data   = '0;

    if (state == ST_BUSY) begin
      o_bus_en    = sel_bus_en;
      o_wr_en     = sel_wr_en;
      o_wr_data   = sel_wr_data;
      o_addr      = sel_addr;
      o_byte_en   = sel_byte_en;
      o_atomic    = sel_atomic;
      o_operation = sel_operation;
      o_id        = grant;
      for (int k = 0; k < N_PORTS; k++) begin
        if (grant == ID_W'(k)) begin
          o_ack[k]                   = i_ack;
          o_rd_data[k*XLEN +: XLEN]  = i_rd_data;
        end
      end
    end else if (state == ST_LOCKED) begin
      o_id = grant;
    end
  end

  assign o_dbg_state = state;

endmodule

// File: tb/tb_arbiter_nx1.sv
// -----------------------------------------------------------------------------
// tb_arbiter_nx1
//
// Directed bench for arbiter_nx1 with N_PORTS = 4, XLEN = 32,
// LOCK_TIMEOUT = 16. Two instances share the same stimulus: dut_rr
// (round-robin) and dut_fp (fixed priority). Each step drives inputs just
// after a rising edge, then checks outputs 1 ns later, well clear of the edge.
// -----------------------------------------------------------------------------
module tb_arbiter_nx1;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int IDW  = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared stimulus
  logic [N-1:0]      bus_en, wr_en, atomic, lock;
  logic [N*XLEN-1:0] wr_data, addr;
  logic [N*4-1:0]    byte_en;
  logic [N*7-1:0]    operation;
  logic              ack;
  logic [XLEN-1:0]   rd_data;

  // Round-robin instance outputs
  logic [N-1:0]      rr_ack;
  logic [N*XLEN-1:0] rr_rd_data;
  logic [IDW-1:0]    rr_id;
  logic              rr_bus_en, rr_wr_en, rr_atomic;
  logic [XLEN-1:0]   rr_wr_data, rr_addr;
  logic [3:0]        rr_byte_en;
  logic [6:0]        rr_operation;
  logic [1:0]        rr_state;

  // Fixed-priority instance outputs
  logic [N-1:0]      fp_ack;
  logic [N*XLEN-1:0] fp_rd_data;
  logic [IDW-1:0]    fp_id;
  logic              fp_bus_en, fp_wr_en, fp_atomic;
  logic [XLEN-1:0]   fp_wr_data, fp_addr;
  logic [3:0]        fp_byte_en;
  logic [6:0]        fp_operation;
  logic [1:0]        fp_state;

  arbiter_nx1 #(.N_PORTS(N), .XLEN(XLEN), .ROUND_ROBIN(1), .LOCK_TIMEOUT(16)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_en(bus_en), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_addr(addr),
    .i_byte_en(byte_en), .i_atomic(atomic), .i_operation(operation), .i_lock(lock),
    .o_ack(rr_ack), .o_rd_data(rr_rd_data),
    .i_ack(ack), .i_rd_data(rd_data), .o_id(rr_id),
    .o_bus_en(rr_bus_en), .o_wr_en(rr_wr_en), .o_wr_data(rr_wr_data), .o_addr(rr_addr),
    .o_byte_en(rr_byte_en), .o_atomic(rr_atomic), .o_operation(rr_operation),
    .o_dbg_state(rr_state)
  );

  arbiter_nx1 #(.N_PORTS(N), .XLEN(XLEN), .ROUND_ROBIN(0), .LOCK_TIMEOUT(16)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_en(bus_en), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_addr(addr),
    .i_byte_en(byte_en), .i_atomic(atomic), .i_operation(operation), .i_lock(lock),
    .o_ack(fp_ack), .o_rd_data(fp_rd_data),
    .i_ack(ack), .i_rd_data(rd_data), .o_id(fp_id),
    .o_bus_en(fp_bus_en), .o_wr_en(fp_wr_en), .o_wr_data(fp_wr_data), .o_addr(fp_addr),
    .o_byte_en(fp_byte_en), .o_atomic(fp_atomic), .o_operation(fp_operation),
    .o_dbg_state(fp_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  logic [IDW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [XLEN-1:0] v);
    addr[k*XLEN +: XLEN] = v;
  endtask

  // Watchdog: every step is bounded, this only guards against a stuck clock.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [N-1:0]    wr_pat;
  logic [IDW-1:0]  exp_id;
  logic [XLEN-1:0] exp_addr;
  logic [N-1:0]    one_hot;

  initial begin
    wr_pat    = 4'b1010;
    rst_n     = 1'b0;
    bus_en    = 4'b1111;
    wr_en     = wr_pat;
    atomic    = '0;
    lock      = '0;
    byte_en   = '1;
    operation = '0;
    ack       = 1'b1;           // must not leak through while in reset
    rd_data   = 32'h1234_5678;
    wr_data   = '0;
    addr      = '0;
    for (int k = 0; k < N; k++) begin
      set_addr(k, 32'h1000_0000 + 32'(k) * 32'h100);
      wr_data[k*XLEN +: XLEN] = 32'hA0 + 32'(k);
    end

    // ---- Reset held with all requests high
    cyc();
    #1;
    check("rst_bus_en",  {127'd0, rr_bus_en}, 128'd0);
    check("rst_id",      {126'd0, rr_id},     128'd0);
    check("rst_ack",     {124'd0, rr_ack},    128'd0);
    check("rst_rd_data", rr_rd_data,          128'd0);
    check("rst_addr",    {96'd0, rr_addr},    128'd0);
    check("rst_state",   {126'd0, rr_state},  {126'd0, S_IDLE});

    // ---- Release: IDLE for one cycle, then port 0 granted
    cyc();
    ack   = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_idle_bus_en", {127'd0, rr_bus_en}, 128'd0);

    // ---- Round-robin rotation 0,1,2,3,0 with one-cycle acks
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int n = 0; n < 5; n++) begin
      cyc();
      ack = 1'b1;
      #1;
      exp_id   = exp_q.pop_front();
      exp_addr = 32'h1000_0000 + 32'(exp_id) * 32'h100;
      one_hot  = 4'b0001 << exp_id;
      check("rr_id",     {126'd0, rr_id},     {126'd0, exp_id});
      check("rr_bus_en", {127'd0, rr_bus_en}, 128'd1);
      check("rr_ack",    {124'd0, rr_ack},    {124'd0, one_hot});
      check("rr_addr",   {96'd0, rr_addr},    {96'd0, exp_addr});
      check("rr_wr_en",  {127'd0, rr_wr_en},  {127'd0, wr_pat[exp_id]});
      cyc();
      ack = 1'b0;
      if (n == 4) bus_en = '0;
      #1;
      check("rr_gap_ack",    {124'd0, rr_ack},    128'd0);
      check("rr_gap_bus_en", {127'd0, rr_bus_en}, 128'd0);
    end

    // ---- Data routing: port 2 reads 0x8000_0010, slave returns 0xDEAD_BEEF
    cyc();
    bus_en = 4'b0100;
    wr_en  = '0;
    set_addr(2, 32'h8000_0010);
    #1;
    check("rd_idle_bus_en", {127'd0, rr_bus_en}, 128'd0);
    cyc();
    ack     = 1'b1;
    rd_data = 32'hDEAD_BEEF;
    #1;
    check("rd_addr",    {96'd0, rr_addr},   {96'd0, 32'h8000_0010});
    check("rd_id",      {126'd0, rr_id},    128'd2);
    check("rd_rd_data", rr_rd_data,         {32'h0, 32'hDEAD_BEEF, 64'h0});
    check("rd_ack",     {124'd0, rr_ack},   {124'd0, 4'b0100});
    check("rd_wr_en",   {127'd0, rr_wr_en}, 128'd0);
    // ack held high into IDLE must not be routed
    cyc();
    bus_en = '0;
    #1;
    check("idle_ack_ignored",  {124'd0, rr_ack}, 128'd0);
    check("idle_rd_data_zero", rr_rd_data,       128'd0);
    ack = 1'b0;

    // ---- Lock held: port 0 atomic+lock, port 1 waiting (last = 2)
    cyc();
    bus_en = 4'b0011;
    lock   = 4'b0001;
    atomic = 4'b0001;
    operation[6:0] = 7'h08;
    #1;
    check("lk_idle", {126'd0, rr_state}, {126'd0, S_IDLE});
    cyc();
    ack = 1'b1;                                   // ack cycle t
    #1;
    check("lk_id0",        {126'd0, rr_id},        128'd0);
    check("lk_atomic",     {127'd0, rr_atomic},    128'd1);
    check("lk_operation",  {121'd0, rr_operation}, {121'd0, 7'h08});
    check("lk_ack",        {124'd0, rr_ack},       {124'd0, 4'b0001});
    cyc();                                        // t+1
    ack    = 1'b0;
    bus_en = 4'b0010;
    #1;
    check("lk_state",  {126'd0, rr_state},  {126'd0, S_LOCKED});
    check("lk_bus_en", {127'd0, rr_bus_en}, 128'd0);
    check("lk_hold_id",{126'd0, rr_id},     128'd0);
    cyc();                                        // t+2
    #1;
    check("lk_port1_ignored", {126'd0, rr_state}, {126'd0, S_LOCKED});
    cyc();                                        // t+3: holder re-requests
    bus_en = 4'b0011;
    #1;
    check("lk_rereq_state", {126'd0, rr_state}, {126'd0, S_LOCKED});
    cyc();
    ack  = 1'b1;
    lock = 4'b0000;
    #1;
    check("lk_regrant_id",  {126'd0, rr_id},     128'd0);
    check("lk_regrant_bus", {127'd0, rr_bus_en}, 128'd1);
    cyc();
    ack    = 1'b0;
    bus_en = 4'b0010;
    atomic = '0;
    #1;
    check("lk_release_idle", {126'd0, rr_state}, {126'd0, S_IDLE});
    cyc();
    ack = 1'b1;
    #1;
    check("lk_port1_id",  {126'd0, rr_id},  128'd1);
    check("lk_port1_ack", {124'd0, rr_ack}, {124'd0, 4'b0010});
    cyc();
    ack    = 1'b0;
    bus_en = '0;
    #1;

    // ---- Lock timeout: holder never re-requests (last = 1 -> port 0 next)
    cyc();
    bus_en = 4'b0011;
    lock   = 4'b0001;
    #1;
    check("to_idle", {126'd0, rr_state}, {126'd0, S_IDLE});
    cyc();
    ack = 1'b1;                                   // ack cycle t
    #1;
    check("to_id0", {126'd0, rr_id}, 128'd0);
    for (int j = 1; j <= 16; j++) begin
      cyc();
      if (j == 1) begin
        ack    = 1'b0;
        bus_en = 4'b0010;
      end
      #1;
      check("to_locked", {126'd0, rr_state}, {126'd0, S_LOCKED});
    end
    cyc();                                        // t+17
    #1;
    check("to_released", {126'd0, rr_state},  {126'd0, S_IDLE});
    check("to_rel_bus",  {127'd0, rr_bus_en}, 128'd0);
    cyc();                                        // t+18
    #1;
    check("to_port1_id",  {126'd0, rr_id},     128'd1);
    check("to_port1_bus", {127'd0, rr_bus_en}, 128'd1);
    ack = 1'b1;
    cyc();
    ack    = 1'b0;
    bus_en = '0;
    lock   = '0;
    #1;

    // ---- Asynchronous reset in the middle of a transaction
    cyc();
    bus_en = 4'b0001;
    #1;
    cyc();
    #1;
    check("ar_busy_bus", {127'd0, rr_bus_en}, 128'd1);
    ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_bus_drop", {127'd0, rr_bus_en}, 128'd0);
    check("ar_no_ack",   {124'd0, rr_ack},    128'd0);
    check("ar_state",    {126'd0, rr_state},  {126'd0, S_IDLE});

    // ---- Fixed priority: ports 1 and 3 request
    cyc();
    ack    = 1'b0;
    bus_en = 4'b1010;
    rst_n  = 1'b1;
    #1;
    check("fp_idle", {127'd0, fp_bus_en}, 128'd0);
    cyc();
    ack = 1'b1;
    #1;
    check("fp_first_id",  {126'd0, fp_id},  128'd1);
    check("fp_first_ack", {124'd0, fp_ack}, {124'd0, 4'b0010});
    cyc();
    ack = 1'b0;
    #1;
    check("fp_gap", {127'd0, fp_bus_en}, 128'd0);
    cyc();
    ack = 1'b1;
    #1;
    check("fp_second_id", {126'd0, fp_id}, 128'd1);
    cyc();
    ack    = 1'b0;
    bus_en = 4'b1000;
    #1;
    cyc();
    ack = 1'b1;
    #1;
    check("fp_port3_id",  {126'd0, fp_id},  128'd3);
    check("fp_port3_ack", {124'd0, fp_ack}, {124'd0, 4'b1000});
    cyc();
    ack    = 1'b0;
    bus_en = '0;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
